alarm_set_bank: RTL and testbench

- Clocked, parametrised successor to the single alarm-limit setter.
- Holds NUM_CH independent alarm times (hour 0-23, minute 0-59).
- Sets the selected channel with edge-detected hour and minute buttons, with hold-to-auto-repeat.
- Outputs the selected channel in binary and BCD, keeps a per-channel arm bit, and pulses a per-channel hit flag when the running clock time matches an armed alarm.

---
 rtl/alarm_set_bank.sv | 189 ++++++++++++++++++
 tb/tb_alarm_set_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alarm_set_bank.sv
// alarm_set_bank: NUM_CH alarm times (hh:mm) with one shared button setter.
// The setter uses edge detect plus hold-to-auto-repeat. The bank also holds
// per-channel arm bits and one-cycle hit pulses.
// Optional feature macro ALARM_SET_DEC_EN adds a 'dec' input. While dec is
// high, every setter event decrements the field instead of incrementing it.

// One alarm channel: stored time, arm bit, match edge -> hit pulse.
module alarm_ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev,        // apply one step to this channel
  input  logic       ev_min,    // 1: step minute, 0: step hour
  input  logic       dec,
  input  logic       tgl,
  input  logic       set_en,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic       armed,
  output logic       hit
);
  logic match, match_q;

  assign match = armed && (hour == cur_hour) && (minute == cur_min) && !set_en;

  // Time/arm storage and rising-edge detect of the match condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour    <= '0;
      minute  <= '0;
      armed   <= 1'b0;
      match_q <= 1'b0;
      hit     <= 1'b0;
    end else begin
      if (ev && ev_min)
        minute <= dec ? ((minute == 6'd0) ? 6'd59 : minute - 6'd1)
                      : ((minute == 6'd59) ? 6'd0 : minute + 6'd1);
      if (ev && !ev_min)
        hour <= dec ? ((hour == 6'd0) ? 6'd23 : hour - 6'd1)
                    : ((hour == 6'd23) ? 6'd0 : hour + 6'd1);
      if (tgl) armed <= ~armed;
      match_q <= match;
      hit     <= match && !match_q;
    end
  end
endmodule

module alarm_set_bank #(
  parameter int NUM_CH        = 4,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int SEL_W         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              hour_set,
  input  logic              min_set,
  input  logic              arm_tgl,
`ifdef ALARM_SET_DEC_EN
  input  logic              dec,
`endif
  input  logic [5:0]        cur_hour,
  input  logic [5:0]        cur_min,
  output logic [5:0]        sel_hour,
  output logic [5:0]        sel_min,
  output logic [3:0]        hour_tens,
  output logic [3:0]        hour_ones,
  output logic [3:0]        min_tens,
  output logic [3:0]        min_ones,
  output logic [NUM_CH-1:0] armed,
  output logic [NUM_CH-1:0] alarm_hit
);
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic dec_w;
`ifdef ALARM_SET_DEC_EN
  assign dec_w = dec;
`else
  assign dec_w = 1'b0;
`endif

  state_t             state;
  logic               act_min;
  logic [CNT_W-1:0]   cnt;
  logic               hr_q, mn_q, at_q, rdy;
  logic [SEL_W-1:0]   ch_sel_q;
  logic               hr_rise, mn_rise, at_rise;
  logic               sel_ok, abort, ev, ev_min;
  logic [NUM_CH-1:0]  ev_ch, tgl_ch;
  logic [NUM_CH-1:0][5:0] hour_v, min_v;

  // rdy blocks edge detection on the first cycle after reset so a button
  // already held through reset release is not seen as a fresh press.
  assign hr_rise = rdy && hour_set && !hr_q;
  assign mn_rise = rdy && min_set  && !mn_q;
  assign at_rise = rdy && arm_tgl  && !at_q;
  assign sel_ok  = ({1'b0, ch_sel} < (SEL_W+1)'(NUM_CH));
  assign abort   = !(act_min ? min_set : hour_set) || !set_en || (ch_sel != ch_sel_q);

  // Step-event decode: press edge in IDLE, counter terminal count otherwise.
  always_comb begin
    ev     = 1'b0;
    ev_min = act_min;
    case (state)
      IDLE: begin
        if (set_en && hr_rise) begin
          ev = 1'b1; ev_min = 1'b0;
        end else if (set_en && mn_rise && !hour_set) begin
          ev = 1'b1; ev_min = 1'b1;
        end
      end
      HOLD:    ev = !abort && (cnt == CNT_W'(HOLD_CYCLES - 1));
      REPEAT:  ev = !abort && (cnt == CNT_W'(REPEAT_CYCLES - 1));
      default: ev = 1'b0;
    endcase
  end

  // Input edge registers and previous channel select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= 1'b0; mn_q <= 1'b0; at_q <= 1'b0; rdy <= 1'b0;
      ch_sel_q <= '0;
    end else begin
      hr_q <= hour_set; mn_q <= min_set; at_q <= arm_tgl; rdy <= 1'b1;
      ch_sel_q <= ch_sel;
    end
  end

  // Hold / auto-repeat FSM tracking a single active button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      act_min <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (ev) begin
          state <= HOLD; act_min <= ev_min; cnt <= '0;
        end
        HOLD: begin
          if (abort) begin
            state <= IDLE; cnt <= '0;
          end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state <= REPEAT; cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
        REPEAT: begin
          if (abort) begin
            state <= IDLE; cnt <= '0;
          end else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) cnt <= '0;
          else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ev_ch[i]  = ev && sel_ok && (ch_sel == SEL_W'(i));
    assign tgl_ch[i] = at_rise && set_en && sel_ok && (ch_sel == SEL_W'(i));
    alarm_ch u_ch (
      .clk(clk), .rst_n(rst_n), .ev(ev_ch[i]), .ev_min(ev_min), .dec(dec_w),
      .tgl(tgl_ch[i]), .set_en(set_en), .cur_hour(cur_hour), .cur_min(cur_min),
      .hour(hour_v[i]), .minute(min_v[i]), .armed(armed[i]), .hit(alarm_hit[i])
    );
  end

  // Selected-channel readout; an out-of-range select reads zero.
  always_comb begin
    sel_hour = '0;
    sel_min  = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == SEL_W'(i)) begin
        sel_hour = hour_v[i];
        sel_min  = min_v[i];
      end
  end

  assign hour_tens = 4'(sel_hour / 6'd10);
  assign hour_ones = 4'(sel_hour % 6'd10);
  assign min_tens  = 4'(sel_min / 6'd10);
  assign min_ones  = 4'(sel_min % 6'd10);
endmodule

// File: tb/tb_alarm_set_bank.sv
// Directed bench for alarm_set_bank (HOLD=4, REPEAT=2, 4 channels).
module tb_alarm_set_bank;
  logic       clk = 1'b0;
  logic       rst_n, set_en, hour_set, min_set, arm_tgl;
  logic [1:0] ch_sel;
  logic [5:0] cur_hour, cur_min, sel_hour, sel_min;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones, armed, alarm_hit;
  int total = 0, bad = 0;

  alarm_set_bank #(.NUM_CH(4), .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .set_en(set_en), .ch_sel(ch_sel),
    .hour_set(hour_set), .min_set(min_set), .arm_tgl(arm_tgl),
    .cur_hour(cur_hour), .cur_min(cur_min), .sel_hour(sel_hour), .sel_min(sel_min),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens), .min_ones(min_ones),
    .armed(armed), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin hour_set = 1'b1; tick(); hour_set = 1'b0; tick(); end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin min_set = 1'b1; tick(); min_set = 1'b0; tick(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_min[9] = '{58, 58, 58, 58, 59, 59, 0, 0, 1};
    rst_n = 1'b0; set_en = 1'b0; ch_sel = 2'd0; hour_set = 1'b0; min_set = 1'b0;
    arm_tgl = 1'b0; cur_hour = 6'd0; cur_min = 6'd0;
    tick(); tick();
    chk("rst_sel_hour", sel_hour, 0);
    chk("rst_armed", armed, 0);
    chk("rst_hit", alarm_hit, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 1: three single-cycle hour presses on channel 2
    set_en = 1'b1; ch_sel = 2'd2;
    pulse_hour(3);
    chk("t1_hour", sel_hour, 3);
    chk("t1_htens", hour_tens, 0);
    chk("t1_hones", hour_ones, 3);
    ch_sel = 2'd0; #1;
    chk("t1_ch0", sel_hour, 0);
    ch_sel = 2'd1; #1;
    chk("t1_ch1", sel_hour, 0);
    // hour wrap on channel 2
    ch_sel = 2'd2;
    pulse_hour(20);
    chk("wrap_h23_tens", hour_tens, 2);
    chk("wrap_h23_ones", hour_ones, 3);
    pulse_hour(1);
    chk("wrap_h0", sel_hour, 0);

    // 2: channel 1 min 57, hold 9 cycles -> steps at cycles 0,4,6,8
    ch_sel = 2'd1;
    pulse_min(57);
    chk("t2_min57", sel_min, 57);
    min_set = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("t2_hold_c%0d", c), sel_min, exp_min[c]);
      if (c == 4) begin
        chk("t2_m59_tens", min_tens, 5);
        chk("t2_m59_ones", min_ones, 9);
      end
    end
    min_set = 1'b0; tick(); tick();
    chk("t2_final", sel_min, 1);
    chk("t2_mtens", min_tens, 0);
    chk("t2_mones", min_ones, 1);

    // 3: simultaneous hour+min rise on channel 0 acts on hour only
    ch_sel = 2'd0; tick();
    hour_set = 1'b1; min_set = 1'b1; tick();
    chk("t3_hour", sel_hour, 1);
    chk("t3_min", sel_min, 0);
    tick();
    hour_set = 1'b0;
    repeat (6) tick();
    chk("t3_hour_after", sel_hour, 1);
    chk("t3_min_after", sel_min, 0);
    min_set = 1'b0; tick();

    // 4: channel 3 at 07:30, armed, matching clock
    ch_sel = 2'd3;
    pulse_hour(7);
    pulse_min(30);
    arm_tgl = 1'b1; tick(); arm_tgl = 1'b0; tick();
    chk("t4_armed", armed, 4'b1000);
    chk("t4_hit_pre", alarm_hit, 0);
    set_en = 1'b0; cur_hour = 6'd7; cur_min = 6'd30;
    tick();
    chk("t4_hit", alarm_hit, 4'b1000);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t4_nohit_c%0d", c), alarm_hit, 0);
    end
    set_en = 1'b1; tick();
    chk("t4_setmode_nohit", alarm_hit, 0);
    set_en = 1'b0; tick();
    chk("t4_refire", alarm_hit, 4'b1000);
    tick();
    chk("t4_refire_once", alarm_hit, 0);

    // 5: reset mid-hold clears at once; held button after release is ignored
    set_en = 1'b1; ch_sel = 2'd0; tick();
    hour_set = 1'b1;
    repeat (3) tick();
    chk("t5_before_rst", sel_hour, 2);
    rst_n = 1'b0; #1;
    chk("t5_rst_hour", sel_hour, 0);
    chk("t5_rst_armed", armed, 0);
    chk("t5_rst_hit", alarm_hit, 0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t5_no_inc", sel_hour, 0);
    hour_set = 1'b0; tick();

    // 6: channel change mid-hold aborts the hold
    ch_sel = 2'd0; min_set = 1'b1;
    repeat (6) tick();
    chk("t6_ch0_mid", sel_min, 2);
    ch_sel = 2'd1;
    repeat (6) tick();
    chk("t6_ch1_held", sel_min, 0);
    ch_sel = 2'd0; #1;
    chk("t6_ch0_kept", sel_min, 2);
    ch_sel = 2'd1; tick();
    min_set = 1'b0; tick();
    min_set = 1'b1; tick();
    chk("t6_ch1_new", sel_min, 1);
    min_set = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
